// File: rtl/prio_scan_pkg.sv
// prio_scan_pkg
//   Shared definitions for the sequential priority scanner:
//     ps_state_e  - scanner FSM state (PS_IDLE, PS_SCAN)
//     PS_GROUP    - leaf group size of the priority-encoder tree (8 bits)
//     PS_GROUP_W  - index width inside one leaf group
//     ps_idx_w()  - index width needed to address a WIDTH-bit vector
package prio_scan_pkg;

    typedef enum logic [0:0] {
        PS_IDLE = 1'b0,
        PS_SCAN = 1'b1
    } ps_state_e;

    localparam int PS_GROUP   = 8;
    localparam int PS_GROUP_W = 3;

    // At least one index bit, even for a degenerate width.
    function automatic int ps_idx_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/prio_enc_param.sv
// prio_enc_param
//   Combinational priority encoder built as a log-depth tree over 8-bit
//   groups. Each leaf encodes one group; internal nodes pick the winning
//   child according to the scan order.
//   Parameters:
//     WIDTH      - request vector width (>= 2)
//     IDX_W      - index output width
//     MSB_FIRST  - 1: highest set index wins, 0: lowest set index wins
//   Ports:
//     req_vec  in  WIDTH  vector to encode
//     enc_idx  out IDX_W  index of the winning set bit (0 when none set)
//     enc_any  out 1      at least one bit of req_vec is set
module prio_enc_param
    import prio_scan_pkg::*;
#(
    parameter int WIDTH     = 256,
    parameter int IDX_W     = ps_idx_w(WIDTH),
    parameter int MSB_FIRST = 1
) (
    input  logic [WIDTH-1:0] req_vec,
    output logic [IDX_W-1:0] enc_idx,
    output logic             enc_any
);

    // Groups, padded up to a power of two so the tree is a complete heap.
    localparam int NG  = (WIDTH + PS_GROUP - 1) / PS_GROUP;
    localparam int LVL = (NG > 1) ? $clog2(NG) : 0;
    localparam int NP  = 1 << LVL;
    localparam int CW  = $clog2(NP * PS_GROUP);
    localparam int NN  = 2 * NP - 1;

    logic [NP*PS_GROUP-1:0] vec_pad;
    logic                   node_any [NN];
    logic [CW-1:0]          node_idx [NN];

    always_comb begin
        vec_pad              = '0;
        vec_pad[WIDTH-1:0]   = req_vec;
    end

    // Local encode of one 8-bit group; the last match in loop order wins.
    function automatic logic [PS_GROUP_W-1:0] grp_enc(input logic [PS_GROUP-1:0] bits);
        logic [PS_GROUP_W-1:0] r;
        r = '0;
        for (int b = 0; b < PS_GROUP; b++) begin
            if (MSB_FIRST != 0) begin
                if (bits[b]) r = PS_GROUP_W'(b);
            end else begin
                if (bits[PS_GROUP-1-b]) r = PS_GROUP_W'(PS_GROUP-1-b);
            end
        end
        return r;
    endfunction

    // Heap layout: node 0 is the root, children of i are 2i+1 (lower
    // indices) and 2i+2 (higher indices); leaves occupy NP-1 .. 2NP-2.
    genvar gi;
    generate
        for (gi = 0; gi < NP; gi++) begin : g_leaf
            assign node_any[NP-1+gi] = |vec_pad[gi*PS_GROUP +: PS_GROUP];
            // Low bits of gi*8 are zero, so OR-ing in the local index is exact.
            assign node_idx[NP-1+gi] = CW'(gi * PS_GROUP)
                                     | CW'(grp_enc(vec_pad[gi*PS_GROUP +: PS_GROUP]));
        end

        for (gi = 0; gi < NP - 1; gi++) begin : g_node
            assign node_any[gi] = node_any[2*gi+1] | node_any[2*gi+2];
            if (MSB_FIRST != 0) begin : g_msb
                assign node_idx[gi] = node_any[2*gi+2] ? node_idx[2*gi+2] : node_idx[2*gi+1];
            end else begin : g_lsb
                assign node_idx[gi] = node_any[2*gi+1] ? node_idx[2*gi+1] : node_idx[2*gi+2];
            end
        end
    endgenerate

    assign enc_any = node_any[0];
    assign enc_idx = node_any[0] ? node_idx[0][IDX_W-1:0] : '0;

endmodule

// File: rtl/prio_scan.sv
// prio_scan
//   Sequential priority scanner. Accepts a request bitmap over a
//   valid/ready handshake and emits the index of every set bit in priority
//   order, one beat per cycle, flagging the final beat. An all-zero bitmap
//   yields a single beat with out_none set.
//   Optional feature macro: PRIO_SCAN_ABORT_EN adds the abort input, which
//   drops the remainder of a scan in progress.
//   Parameters: WIDTH (>= 2), IDX_W, MSB_FIRST (1: high index first).
//   Ports:
//     clk        in   1      clock, rising edge
//     rst        in   1      asynchronous active-high reset
//     in_valid   in   1      request vector valid
//     in_ready   out  1      block can accept a vector
//     in_vec     in   WIDTH  request bitmap
//     out_valid  out  1      out_idx valid
//     out_ready  in   1      consumer accepts the beat
//     out_idx    out  IDX_W  current highest-priority pending index
//     out_last   out  1      final beat of this vector
//     out_none   out  1      vector was all-zero (single beat)
//     abort      in   1      (PRIO_SCAN_ABORT_EN only) drop the current scan
module prio_scan
    import prio_scan_pkg::*;
#(
    parameter int WIDTH     = 256,
    parameter int IDX_W     = ps_idx_w(WIDTH),
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_none
`ifdef PRIO_SCAN_ABORT_EN
    ,
    input  logic             abort
`endif
);

    ps_state_e        state_q, state_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             none_q, none_d;

    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;
    logic [WIDTH-1:0] pend_clr;
    logic             scan;
    logic             last_beat;
    logic             abort_act;
    logic             xfer;
    logic             load;

    prio_enc_param #(
        .WIDTH     (WIDTH),
        .IDX_W     (IDX_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_enc (
        .req_vec (pend_q),
        .enc_idx (enc_idx),
        .enc_any (enc_any)
    );

    // Pending bits with the current winner removed. If nothing remains the
    // current beat is the last one, which covers both the single-bit and the
    // all-zero case.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_clr
            assign pend_clr[gi] = pend_q[gi] & (enc_idx != IDX_W'(gi));
        end
    endgenerate

    assign scan      = (state_q == PS_SCAN);
    assign last_beat = (pend_clr == '0);

`ifdef PRIO_SCAN_ABORT_EN
    assign abort_act = scan & abort;
`else
    assign abort_act = 1'b0;
`endif

    // Outputs come straight from state; nothing from in_* reaches out_*.
    assign out_valid = scan;
    assign out_idx   = (scan && !none_q && enc_any) ? enc_idx : '0;
    assign out_last  = scan & last_beat;
    assign out_none  = scan & none_q;

    // An aborting cycle neither transfers nor accepts a back-to-back vector.
    assign xfer     = scan & out_ready & ~abort_act;
    assign in_ready = ~scan | (last_beat & xfer);
    assign load     = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        none_d  = none_q;
        if (abort_act) begin
            state_d = PS_IDLE;
            pend_d  = '0;
            none_d  = 1'b0;
        end else if (load) begin
            // Either from IDLE or directly behind the last beat (no bubble).
            state_d = PS_SCAN;
            pend_d  = in_vec;
            none_d  = (in_vec == '0);
        end else if (xfer) begin
            pend_d = pend_clr;
            if (last_beat) begin
                state_d = PS_IDLE;
                none_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PS_IDLE;
            pend_q  <= '0;
            none_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            none_q  <= none_d;
        end
    end

endmodule

// File: tb/tb_prio_scan.sv
module tb_prio_scan;

    localparam int W  = 256;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_vec = '0;
    logic          out_ready = 1'b0;
    logic          abort = 1'b0;

    logic          in_ready_m, out_valid_m, out_last_m, out_none_m;
    logic [IW-1:0] out_idx_m;
    logic          in_ready_l, out_valid_l, out_last_l, out_none_l;
    logic [IW-1:0] out_idx_l;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: the remaining beats of the current vector, in emission order.
    int q_m[$];
    int q_l[$];
    bit m_none = 1'b0;

    always #5 clk = ~clk;

    prio_scan #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_m),
        .in_vec(in_vec), .out_valid(out_valid_m), .out_ready(out_ready),
        .out_idx(out_idx_m), .out_last(out_last_m), .out_none(out_none_m)
`ifdef PRIO_SCAN_ABORT_EN
        , .abort(abort)
`endif
    );

    prio_scan #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l),
        .in_vec(in_vec), .out_valid(out_valid_l), .out_ready(out_ready),
        .out_idx(out_idx_l), .out_last(out_last_l), .out_none(out_none_l)
`ifdef PRIO_SCAN_ABORT_EN
        , .abort(abort)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q_m.delete();
        q_l.delete();
        m_none = 1'b0;
    endtask

    task automatic model_load(input logic [W-1:0] v);
        model_clear();
        for (int i = W - 1; i >= 0; i--) if (v[i]) q_m.push_back(i);
        for (int i = 0; i < W; i++)      if (v[i]) q_l.push_back(i);
        if (q_m.size() == 0) begin
            q_m.push_back(0);
            q_l.push_back(0);
            m_none = 1'b1;
        end
    endtask

    // Compare both DUTs against the reference for the current cycle.
    task automatic compare();
        bit busy;
        int exp_rdy;
        busy    = (q_m.size() > 0);
        exp_rdy = (!busy || (q_m.size() == 1 && out_ready && !abort)) ? 1 : 0;
        chk("valid_m", int'(out_valid_m), int'(busy));
        chk("valid_l", int'(out_valid_l), int'(busy));
        chk("in_ready_m", int'(in_ready_m), exp_rdy);
        chk("in_ready_l", int'(in_ready_l), exp_rdy);
        if (busy) begin
            chk("idx_m",  int'(out_idx_m),  q_m[0]);
            chk("idx_l",  int'(out_idx_l),  q_l[0]);
            chk("last_m", int'(out_last_m), (q_m.size() == 1) ? 1 : 0);
            chk("last_l", int'(out_last_l), (q_l.size() == 1) ? 1 : 0);
            chk("none_m", int'(out_none_m), int'(m_none));
            chk("none_l", int'(out_none_l), int'(m_none));
        end
    endtask

    // One cycle: drive at the falling edge, sample 1ns later, then advance
    // the reference by what the coming rising edge will do.
    task automatic step(input logic v, input logic [W-1:0] vec, input logic rdy, input logic ab);
        bit busy, acc, xf;
        @(negedge clk);
        in_valid  = v;
        in_vec    = vec;
        out_ready = rdy;
        abort     = ab;
        #1;
        compare();
        busy = (q_m.size() > 0);
        if (busy && ab) begin
            model_clear();
        end else begin
            xf  = busy && rdy;
            acc = v && (!busy || (q_m.size() == 1 && rdy));
            if (xf) begin
                void'(q_m.pop_front());
                void'(q_l.pop_front());
                if (q_m.size() == 0) m_none = 1'b0;
            end
            if (acc) model_load(vec);
        end
    endtask

    function automatic logic [W-1:0] bits3(input int a, input int b, input int c);
        logic [W-1:0] r;
        r = '0;
        if (a >= 0) r[a] = 1'b1;
        if (b >= 0) r[b] = 1'b1;
        if (c >= 0) r[c] = 1'b1;
        return r;
    endfunction

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] r;
        int mode;
        r = '0;
        mode = int'($urandom_range(0, 7));
        if (mode == 1) begin
            r[$urandom_range(0, W - 1)] = 1'b1;
        end else if (mode >= 2 && mode <= 5) begin
            for (int k = 0; k < int'($urandom_range(1, 8)); k++) r[$urandom_range(0, W - 1)] = 1'b1;
        end else if (mode >= 6) begin
            for (int w = 0; w < W / 32; w++) r[w*32 +: 32] = $urandom & $urandom & $urandom;
        end
        return r;
    endfunction

    initial begin
        logic [W-1:0] v;
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready_m), 1);
        chk("rst_valid",    int'(out_valid_m), 0);
        chk("rst_idx",      int'(out_idx_m), 0);
        chk("rst_last",     int'(out_last_m), 0);
        chk("rst_none",     int'(out_none_m), 0);
        chk("rst_valid_l",  int'(out_valid_l), 0);
        rst = 1'b0;

        // Multi-bit {200,5,0}
        v = bits3(200, 5, 0);
        step(1, v, 1, 0);
        step(0, '0, 1, 0);
        chk("mb_idx0", int'(out_idx_m), 200); chk("mb_last0", int'(out_last_m), 0);
        chk("mb_lidx0", int'(out_idx_l), 0);
        step(0, '0, 1, 0);
        chk("mb_idx1", int'(out_idx_m), 5);   chk("mb_last1", int'(out_last_m), 0);
        step(0, '0, 1, 0);
        chk("mb_idx2", int'(out_idx_m), 0);   chk("mb_last2", int'(out_last_m), 1);
        chk("mb_lidx2", int'(out_idx_l), 200);
        step(0, '0, 1, 0);
        chk("mb_idle", int'(out_valid_m), 0);

        // 0x8001
        v = '0; v[15:0] = 16'h8001;
        step(1, v, 1, 0);
        step(0, '0, 1, 0);
        chk("lsb_idx0", int'(out_idx_l), 0);  chk("lsb_last0", int'(out_last_l), 0);
        step(0, '0, 1, 0);
        chk("lsb_idx1", int'(out_idx_l), 15); chk("lsb_last1", int'(out_last_l), 1);
        step(0, '0, 1, 0);

        // Zero vector
        step(1, '0, 1, 0);
        step(0, '0, 1, 0);
        chk("zero_idx", int'(out_idx_m), 0); chk("zero_none", int'(out_none_m), 1);
        chk("zero_last", int'(out_last_m), 1); chk("zero_valid", int'(out_valid_m), 1);
        step(0, '0, 1, 0);
        chk("zero_idle", int'(out_valid_m), 0);

        // Backpressure {7,3}
        step(1, bits3(7, 3, -1), 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, '0, 0, 0);
            chk("bp_hold", int'(out_idx_m), 7);
        end
        step(0, '0, 1, 0);
        chk("bp_idx7", int'(out_idx_m), 7);
        step(0, '0, 1, 0);
        chk("bp_idx3", int'(out_idx_m), 3); chk("bp_last", int'(out_last_m), 1);
        step(0, '0, 1, 0);

        // Back-to-back {4} then {9}
        step(1, bits3(4, -1, -1), 1, 0);
        step(1, bits3(9, -1, -1), 1, 0);
        chk("b2b_idx4", int'(out_idx_m), 4); chk("b2b_rdy", int'(in_ready_m), 1);
        step(0, '0, 1, 0);
        chk("b2b_valid", int'(out_valid_m), 1); chk("b2b_idx9", int'(out_idx_m), 9);
        step(0, '0, 1, 0);

        // Reset mid-scan {100,50}
        step(1, bits3(100, 50, -1), 1, 0);
        step(0, '0, 0, 0);
        chk("rs_idx", int'(out_idx_m), 100);
        #1 rst = 1'b1;
        #1;
        chk("rs_valid_now", int'(out_valid_m), 0);
        chk("rs_valid_now_l", int'(out_valid_l), 0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        step(0, '0, 1, 0);
        chk("rs_in_ready", int'(in_ready_m), 1);

`ifdef PRIO_SCAN_ABORT_EN
        // Abort on first beat of {100,50}
        step(1, bits3(100, 50, -1), 1, 0);
        step(1, bits3(1, -1, -1), 1, 1);
        chk("ab_idx", int'(out_idx_m), 100);
        step(0, '0, 1, 0);
        chk("ab_idle", int'(out_valid_m), 0);
        // Abort ignored in IDLE
        step(1, bits3(2, -1, -1), 1, 1);
        step(0, '0, 1, 0);
        chk("ab_idle_ign", int'(out_idx_m), 2);
`endif

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            logic ab;
            ab = 1'b0;
`ifdef PRIO_SCAN_ABORT_EN
            ab = ($urandom_range(0, 39) == 0);
`endif
            step(($urandom_range(0, 9) < 6), rand_vec(), ($urandom_range(0, 3) != 0), ab);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
